phase_sequencer: RTL and testbench

- Parametrised successor to the core's fixed clock divider and phase generator.
- Runs on the single system clock and generates one-hot phase-enable levels and start strobes (fetch, reg, alu, ram, ...) instead of derived clocks.
- Phase count, per-phase dwell and the stall-on-execute phase are configurable. Adds run/stop/single-step modes, a wait timeout and a retired-instruction counter.
- Sits between the top level and the core; every core register uses clk qualified by phase_act/phase_start.

---
 rtl/phase_sequencer_pkg.sv | 19 +
 rtl/phase_sequencer_timer.sv | 31 +++
 rtl/phase_sequencer.sv | 119 +++++++++++
 tb/tb_phase_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared encodings for the phase sequencer: operating modes and FSM states.
package phase_seq_pkg;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // True when an idle sequencer should begin a new instruction.
    function automatic logic mode_starts(input logic [1:0] mode, input logic step);
        return (mode == MODE_RUN) || ((mode == MODE_STEP) && step);
    endfunction

endpackage

// File: rtl/phase_sequencer_timer.sv
// Loadable down-counter that stops at zero; expired_o flags the last dwell cycle.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Single-clock phase sequencer: one-hot phase enables/strobes, exec_done stall with
// timeout, run/stop/single-step control and a retired-instruction counter.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 5,
    parameter int LEN_W      = 4,
    parameter int WAIT_PHASE = 2,
    parameter int TIMEOUT    = 255,
    parameter int RET_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mode,
    input  logic                        step,
    input  logic [NUM_PHASES*LEN_W-1:0] phase_len,
    input  logic                        exec_done,
    output logic [NUM_PHASES-1:0]       phase_act,
    output logic [NUM_PHASES-1:0]       phase_start,
    output logic                        inst_done,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [RET_W-1:0]            retired
);

    if (NUM_PHASES < 2 || WAIT_PHASE >= NUM_PHASES) begin : g_bad_cfg
        $error("phase_sequencer: need NUM_PHASES >= 2 and WAIT_PHASE < NUM_PHASES");
    end

    localparam int PH_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PH_W-1:0] LAST_IDX = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W-1:0] WAIT_IDX = PH_W'(WAIT_PHASE);

    state_t                  state_q;
    logic [PH_W-1:0]         idx_q;
    logic [NUM_PHASES-1:0]   act_q, start_q;
    logic [RET_W-1:0]        ret_q;
    logic                    err_q, seen_q;
    logic [WC_W-1:0]         wcnt_q;

    logic                    dwell_exp, timed_out, last_cycle, wrap, start_req, enter;
    logic [PH_W-1:0]         next_idx;
    logic [NUM_PHASES-1:0]   next_onehot;
    logic [LEN_W-1:0]        next_len;

    always_comb begin
        timed_out  = (TIMEOUT != 0) && (wcnt_q == WC_W'(TIMEOUT)) && !exec_done;
        last_cycle = 1'b0;
        case (state_q)
            PHASE:   last_cycle = dwell_exp && ((idx_q != WAIT_IDX) || seen_q || exec_done);
            WAIT:    last_cycle = exec_done || timed_out;
            default: last_cycle = 1'b0;
        endcase
        start_req = (state_q == IDLE) && mode_starts(mode, step);
        wrap      = last_cycle && (idx_q == LAST_IDX);
        // Run mode chains straight into the next instruction without a bubble.
        enter     = start_req || (last_cycle && (!wrap || (mode == MODE_RUN)));
        next_idx  = (start_req || wrap) ? '0 : idx_q + 1'b1;
        next_len  = phase_len[next_idx*LEN_W +: LEN_W];
    end

    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_onehot
        assign next_onehot[gi] = (next_idx == PH_W'(gi));
    end

    phase_timer #(.W(LEN_W)) u_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (enter),
        .value_i   (next_len),
        .expired_o (dwell_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            act_q   <= '0;
            start_q <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            start_q <= '0;
            if ((state_q == WAIT) && timed_out)
                err_q <= 1'b1;
            if (wrap)
                ret_q <= ret_q + 1'b1;
            if (enter) begin
                state_q <= PHASE;
                idx_q   <= next_idx;
                act_q   <= next_onehot;
                start_q <= next_onehot;
                seen_q  <= 1'b0;
            end else if (last_cycle) begin
                state_q <= IDLE;
                act_q   <= '0;
            end else begin
                seen_q <= seen_q | exec_done;
                if ((state_q == PHASE) && dwell_exp) begin
                    state_q <= WAIT;
                    wcnt_q  <= WC_W'(1);
                end else if (state_q == WAIT) begin
                    wcnt_q  <= wcnt_q + 1'b1;
                end
            end
        end
    end

    assign phase_act   = act_q;
    assign phase_start = start_q;
    assign inst_done   = wrap;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;
    assign retired     = ret_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: constant vector table, directed corner sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_phase_sequencer;

    localparam int NP = 5;
    localparam int WP = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        step = 1'b0;
    logic        exec_done = 1'b0;
    logic [19:0] phase_len = '0;
    logic [4:0]  phase_act, phase_start;
    logic        inst_done, busy, timeout_err;
    logic [3:0]  retired;

    phase_sequencer #(
        .NUM_PHASES(NP), .LEN_W(4), .WAIT_PHASE(WP), .TIMEOUT(TO), .RET_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .step(step), .phase_len(phase_len),
        .exec_done(exec_done), .phase_act(phase_act), .phase_start(phase_start),
        .inst_done(inst_done), .busy(busy), .timeout_err(timeout_err), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: busy flag, phase number, cycles elapsed in phase, sampled dwell.
    int m_busy, m_ph, m_el, m_dw, m_done, m_ret, m_err, m_last, m_to;
    int e_act, e_start, e_done;
    logic [4:0] o_act, o_start;
    logic       o_done, o_busy, o_err;
    logic [3:0] o_ret;

    function automatic int fld(input logic [19:0] ln, input int k);
        logic [19:0] s;
        s = ln >> (k * 4);
        return int'(s[3:0]);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ph = 0; m_el = 0; m_dw = 0; m_done = 0; m_ret = 0; m_err = 0;
    endtask

    task automatic model_enter(input int k);
        m_busy = 1; m_ph = k; m_el = 0; m_dw = fld(phase_len, k); m_done = 0;
    endtask

    task automatic model_eval();
        int seen;
        e_act   = m_busy ? (1 << m_ph) : 0;
        e_start = (m_busy != 0 && m_el == 0) ? e_act : 0;
        seen    = (m_done != 0 || exec_done) ? 1 : 0;
        m_last  = 0;
        m_to    = 0;
        if (m_busy != 0) begin
            if (m_ph != WP)        m_last = (m_el == m_dw) ? 1 : 0;
            else if (m_el == m_dw) m_last = seen;
            else if (m_el > m_dw) begin
                if (exec_done) m_last = 1;
                else if (m_el - m_dw == TO) begin m_last = 1; m_to = 1; end
            end
        end
        e_done = (m_last != 0 && m_ph == NP - 1) ? 1 : 0;
    endtask

    task automatic model_step();
        if (m_to != 0) m_err = 1;
        if (m_busy == 0) begin
            if (mode == 2'b01 || (mode == 2'b10 && step)) model_enter(0);
        end else if (m_last != 0) begin
            if (m_ph == NP - 1) begin
                m_ret = (m_ret + 1) % 16;
                if (mode == 2'b01) model_enter(0);
                else m_busy = 0;
            end else begin
                model_enter(m_ph + 1);
            end
        end else begin
            m_el++;
            if (exec_done) m_done = 1;
        end
    endtask

    task automatic cycle(input logic [1:0] md, input logic st, input logic ex, input logic [19:0] ln);
        mode = md; step = st; exec_done = ex; phase_len = ln;
        @(negedge clk);
        o_act = phase_act; o_start = phase_start; o_done = inst_done;
        o_busy = busy; o_err = timeout_err; o_ret = retired;
        model_eval();
        chk("act", int'(o_act), e_act);
        chk("start", int'(o_start), e_start);
        chk("inst_done", int'(o_done), e_done);
        chk("busy", int'(o_busy), m_busy);
        chk("retired", int'(o_ret), m_ret);
        chk("timeout_err", int'(o_err), m_err);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_act"}, int'(phase_act), 0);
        chk({nm, "_start"}, int'(phase_start), 0);
        chk({nm, "_done"}, int'(inst_done), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_ret"}, int'(retired), 0);
        chk({nm, "_err"}, int'(timeout_err), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] md; logic st; logic ex; logic [19:0] ln;
        logic [4:0] act; logic [4:0] start; logic done; logic bsy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_busy, cnt_act2, cnt_st2, cnt_act1, cnt_done, n, r0;
        logic prev_done;

        tbl[0] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b00000, 5'b00000, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b00001, 5'b00001, 1'b0, 1'b1};
        tbl[2] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b00010, 5'b00010, 1'b0, 1'b1};
        tbl[3] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b00100, 5'b00100, 1'b0, 1'b1};
        tbl[4] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b01000, 5'b01000, 1'b0, 1'b1};
        tbl[5] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b10000, 5'b10000, 1'b1, 1'b1};
        tbl[6] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b00001, 5'b00001, 1'b0, 1'b1};
        tbl[7] = '{2'b01, 1'b0, 1'b1, 20'h0, 5'b00010, 5'b00010, 1'b0, 1'b1};

        do_reset();

        // Single-cycle phases in run mode, back-to-back instructions.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].md, tbl[i].st, tbl[i].ex, tbl[i].ln);
            chk("t1_act", int'(o_act), int'(tbl[i].act));
            chk("t1_start", int'(o_start), int'(tbl[i].start));
            chk("t1_done", int'(o_done), int'(tbl[i].done));
            chk("t1_busy", int'(o_busy), int'(tbl[i].bsy));
        end
        for (int i = 0; i < 13; i++) cycle(2'b01, 1'b0, 1'b1, 20'h0);
        cycle(2'b01, 1'b0, 1'b1, 20'h0);
        chk("t1_retired20", int'(o_ret), 4);
        for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0, 1'b1, 20'h0);
        chk("t1_stopped", int'(o_busy), 0);

        // Dwell fields plus a late exec_done in the wait phase.
        cnt_busy = 0; cnt_act2 = 0; cnt_st2 = 0; cnt_act1 = 0;
        for (int j = 0; j < 16; j++) begin
            cycle(2'b10, (j == 0), (j == 10), 20'h00210);
            if (o_busy) cnt_busy++;
            if (o_act[2]) cnt_act2++;
            if (o_start[2]) cnt_st2++;
            if (o_act[1]) cnt_act1++;
        end
        chk("t2_inst_len", cnt_busy, 12);
        chk("t2_ph1_len", cnt_act1, 2);
        chk("t2_ph2_len", cnt_act2, 7);
        chk("t2_ph2_starts", cnt_st2, 1);

        // Single-step: a step while busy is ignored.
        cnt_done = 0; r0 = 0;
        for (int j = 0; j < 11; j++) begin
            cycle(2'b10, (j == 0 || j == 3), 1'b1, 20'h0);
            if (j == 0) r0 = int'(o_ret);
            if (o_done) cnt_done++;
            if (j == 6) chk("t3_busy_fall", int'(o_busy), 0);
        end
        chk("t3_one_inst", cnt_done, 1);
        chk("t3_retired", int'(o_ret), (r0 + 1) % 16);
        cycle(2'b10, 1'b1, 1'b1, 20'h0);
        cycle(2'b10, 1'b0, 1'b1, 20'h0);
        chk("t3_restep", int'(o_busy), 1);
        for (int j = 0; j < 6; j++) cycle(2'b10, 1'b0, 1'b1, 20'h0);

        // Wait timeout with exec_done never asserted; flag must stay sticky.
        cnt_act2 = 0;
        for (int j = 0; j < 20; j++) begin
            cycle(2'b10, (j == 0), 1'b0, 20'h0);
            if (o_act[2]) cnt_act2++;
        end
        chk("t4_ph2_len", cnt_act2, 1 + TO);
        chk("t4_err", int'(o_err), 1);
        for (int j = 0; j < 8; j++) cycle(2'b10, (j == 0), 1'b1, 20'h0);
        chk("t4_err_sticky", int'(o_err), 1);

        // Graceful stop: mode drops to stop during phase 1.
        for (int j = 0; j < 8; j++) begin
            cycle((j < 2) ? 2'b01 : 2'b00, 1'b0, 1'b1, 20'h0);
            if (j == 5) chk("t5_done", int'(o_done), 1);
            if (j == 6) chk("t5_idle", int'(o_busy), 0);
        end
        // Asynchronous reset in the middle of phase 3.
        for (int j = 0; j < 4; j++) cycle(2'b01, 1'b0, 1'b1, 20'h0);
        chk("t5_in_ph3", int'(phase_act), 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Retired counter wraps after 16 instructions.
        n = 0; prev_done = 1'b0;
        for (int j = 0; j < 85; j++) begin
            cycle(2'b01, 1'b0, 1'b1, 20'h0);
            if (prev_done) chk("t6_retired", int'(o_ret), n % 16);
            prev_done = o_done;
            if (o_done) n++;
        end
        chk("t6_count", n, 16);
        for (int j = 0; j < 8; j++) cycle(2'b00, 1'b0, 1'b1, 20'h0);

        // Randomized traffic against the reference model.
        for (int j = 0; j < 3000; j++) begin
            cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 20'($urandom) & 20'h33333);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
